// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_mem_pkg
//  Description : Shared load/store encodings, controller states and the
//                alignment check used by the data-memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Unlisted load funct3 codes are word loads; store size 11 is never legal.
    function automatic logic is_misaligned(
        input logic       i_write,
        input logic [2:0] i_funct3,
        input logic [1:0] i_size,
        input logic [1:0] i_addr_lo
    );
        logic w_mis;
        if (i_write) begin
            case (i_size)
                SZ_B:    w_mis = 1'b0;
                SZ_H:    w_mis = i_addr_lo[0];
                SZ_W:    w_mis = |i_addr_lo;
                default: w_mis = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                F3_LB, F3_LBU: w_mis = 1'b0;
                F3_LH, F3_LHU: w_mis = i_addr_lo[0];
                default:       w_mis = |i_addr_lo;
            endcase
        end
        return w_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_align_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_align_unit
//  Description : Store lane shift / byte-enable generation and load byte/half
//                selection with sign or zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_align_unit
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_byte_en,
    output logic [31:0] o_st_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_byte_en = 4'b0000;
        o_st_data    = i_st_data;
        case (i_st_size)
            SZ_B: begin
                o_st_byte_en = 4'b0001 << i_st_addr_lo;
                o_st_data    = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_st_byte_en = 4'b0011 << i_st_addr_lo;
                o_st_data    = {2{i_st_data[15:0]}};
            end
            SZ_W:    o_st_byte_en = 4'b1111;
            default: o_st_byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        w_byte = i_ld_word[{i_ld_addr_lo, 3'b000} +: 8];
        w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_ld_data = {24'h000000, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_ld_data = {16'h0000, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Core load/store port to word-wide req/ack memory bridge with
//                stall generation, misalignment and timeout error reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  DATA_MEM_READ,
    input  logic [2:0]  DATA_MEM_WRITE,
    input  logic [31:0] DATA_MEM_ADDR,
    input  logic [31:0] DATA_MEM_WRITE_DATA,
    output logic [31:0] DATA_MEM_READ_DATA,
    output logic        DATA_MEM_BUSYWAIT,
    output logic        DATA_MEM_ERROR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [29:0] MEM_ADDR,
    output logic [3:0]  MEM_BYTE_EN,
    output logic [31:0] MEM_WRITE_DATA,
    input  logic [31:0] MEM_READ_DATA,
    input  logic        MEM_ACK
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [29:0] r_word_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_byte_en;
    logic        r_err;
    logic [7:0]  r_tmo_cnt;
    logic [31:0] r_rdata;

    logic        w_req_rd;
    logic        w_req_wr;
    logic        w_req;
    logic        w_misaligned;
    logic        w_timeout;
    logic [3:0]  w_st_byte_en;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;

    assign w_req_rd     = DATA_MEM_READ[3];
    assign w_req_wr     = DATA_MEM_WRITE[2];
    assign w_req        = w_req_rd | w_req_wr;
    assign w_misaligned = is_misaligned(w_req_wr, DATA_MEM_READ[2:0],
                                        DATA_MEM_WRITE[1:0], DATA_MEM_ADDR[1:0]);
    // An ack arriving in the final counted cycle still completes the access.
    assign w_timeout    = !MEM_ACK && ((r_tmo_cnt + 8'd1) == c_TIMEOUT);

    data_align_unit u_align (
        .i_st_size    (DATA_MEM_WRITE[1:0]),
        .i_st_addr_lo (DATA_MEM_ADDR[1:0]),
        .i_st_data    (DATA_MEM_WRITE_DATA),
        .o_st_byte_en (w_st_byte_en),
        .o_st_data    (w_st_data),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_word    (MEM_READ_DATA),
        .o_ld_data    (w_ld_data)
    );

    always_comb begin
        w_next_state      = r_state;
        DATA_MEM_BUSYWAIT = 1'b0;
        case (r_state)
            ST_IDLE: begin
                DATA_MEM_BUSYWAIT = w_req;
                if (w_req)
                    w_next_state = w_misaligned ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                DATA_MEM_BUSYWAIT = 1'b1;
                if (MEM_ACK || w_timeout)
                    w_next_state = ST_DONE;
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_word_addr <= 30'd0;
            r_wdata     <= 32'd0;
            r_byte_en   <= 4'b0000;
            r_err       <= 1'b0;
            r_tmo_cnt   <= 8'd0;
            r_rdata     <= 32'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_we        <= w_req_wr;
                        r_funct3    <= DATA_MEM_READ[2:0];
                        r_addr_lo   <= DATA_MEM_ADDR[1:0];
                        r_word_addr <= DATA_MEM_ADDR[31:2];
                        r_wdata     <= w_st_data;
                        r_byte_en   <= w_st_byte_en;
                        r_err       <= w_misaligned;
                        r_tmo_cnt   <= 8'd0;
                        if (w_misaligned)
                            r_rdata <= 32'd0;
                    end
                end
                ST_ACCESS: begin
                    if (MEM_ACK) begin
                        if (!r_we)
                            r_rdata <= w_ld_data;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        if (w_timeout) begin
                            r_rdata <= 32'd0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign MEM_REQ            = (r_state == ST_ACCESS);
    assign MEM_WE             = MEM_REQ & r_we;
    assign MEM_BYTE_EN        = (MEM_REQ && r_we) ? r_byte_en : 4'b0000;
    assign MEM_ADDR           = r_word_addr;
    assign MEM_WRITE_DATA     = r_wdata;
    assign DATA_MEM_READ_DATA = r_rdata;
    assign DATA_MEM_ERROR     = (r_state == ST_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Self-checking bench for data_mem_ctrl (TIMEOUT_CYCLES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  DATA_MEM_READ;
    logic [2:0]  DATA_MEM_WRITE;
    logic [31:0] DATA_MEM_ADDR;
    logic [31:0] DATA_MEM_WRITE_DATA;
    logic [31:0] DATA_MEM_READ_DATA;
    logic        DATA_MEM_BUSYWAIT;
    logic        DATA_MEM_ERROR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [29:0] MEM_ADDR;
    logic [3:0]  MEM_BYTE_EN;
    logic [31:0] MEM_WRITE_DATA;
    logic [31:0] MEM_READ_DATA;
    logic        MEM_ACK;

    always #5 CLK = ~CLK;

    data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .DATA_MEM_READ       (DATA_MEM_READ),
        .DATA_MEM_WRITE      (DATA_MEM_WRITE),
        .DATA_MEM_ADDR       (DATA_MEM_ADDR),
        .DATA_MEM_WRITE_DATA (DATA_MEM_WRITE_DATA),
        .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
        .DATA_MEM_BUSYWAIT   (DATA_MEM_BUSYWAIT),
        .DATA_MEM_ERROR      (DATA_MEM_ERROR),
        .MEM_REQ             (MEM_REQ),
        .MEM_WE              (MEM_WE),
        .MEM_ADDR            (MEM_ADDR),
        .MEM_BYTE_EN         (MEM_BYTE_EN),
        .MEM_WRITE_DATA      (MEM_WRITE_DATA),
        .MEM_READ_DATA       (MEM_READ_DATA),
        .MEM_ACK             (MEM_ACK)
    );

    typedef struct {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          ack;     // ACCESS cycle carrying MEM_ACK, 0 = never
        logic        we;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rdata;
        logic        err;
        int          busy;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[18];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
        input logic [31:0] wdata, input logic [31:0] mem, input int ack,
        input logic we, input logic [3:0] be, input logic [31:0] mwd,
        input logic [31:0] rdata, input logic err, input int busy);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mem = mem;
        v.ack = ack; v.we = we; v.be = be; v.mwd = mwd; v.rdata = rdata;
        v.err = err; v.busy = busy;
        return v;
    endfunction

    // Called on a falling edge; returns on the falling edge of the IDLE cycle after DONE.
    task automatic run_txn(input vec_t v, input int idx);
        exp_t        e;
        exp_t        got_e;
        int          busy = 0;
        int          acc = 0;
        int          err_out = 0;
        bit          done = 0;
        bit          seen = 0;
        logic        we_s = 1'b0;
        logic [3:0]  be_s = 4'b0;
        logic [29:0] ma_s = 30'd0;
        logic [31:0] wd_s = 32'd0;
        logic [29:0] exp_ma;
        string       tag;
        tag = $sformatf("v%0d", idx);
        e.rdata = v.rdata;
        e.err   = v.err;
        sb_q.push_back(e);
        DATA_MEM_READ       = v.rd;
        DATA_MEM_WRITE      = v.wr;
        DATA_MEM_ADDR       = v.addr;
        DATA_MEM_WRITE_DATA = v.wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c == 0) chk({tag, "_req_idle"}, {31'd0, MEM_REQ}, 32'd0);
            if (DATA_MEM_BUSYWAIT) begin
                busy++;
                if (DATA_MEM_ERROR) err_out++;
                if (MEM_REQ) begin
                    acc++;
                    if (!seen) begin
                        seen = 1;
                        we_s = MEM_WE; be_s = MEM_BYTE_EN; ma_s = MEM_ADDR; wd_s = MEM_WRITE_DATA;
                    end
                    MEM_ACK       = (acc == v.ack);
                    MEM_READ_DATA = (acc == v.ack) ? v.mem : $urandom;
                end else begin
                    MEM_ACK = 1'b0;
                end
            end else begin
                done    = 1;
                MEM_ACK = 1'b0;
                got_e   = sb_q.pop_front();
                chk({tag, "_rdata"}, DATA_MEM_READ_DATA, got_e.rdata);
                chk({tag, "_error"}, {31'd0, DATA_MEM_ERROR}, {31'd0, got_e.err});
            end
            @(negedge CLK);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_complete: busywait never dropped, expected drop after %0d cycles", tag, v.busy);
            void'(sb_q.pop_front());
        end
        exp_ma = v.addr[31:2];
        chk({tag, "_busy_cycles"}, busy, v.busy);
        chk({tag, "_req_cycles"}, acc, (v.busy > 1) ? v.busy - 1 : 0);
        chk({tag, "_early_error"}, err_out, 0);
        if (seen) begin
            chk({tag, "_mem_we"}, {31'd0, we_s}, {31'd0, v.we});
            chk({tag, "_mem_addr"}, {2'b00, ma_s}, {2'b00, exp_ma});
            chk({tag, "_byte_en"}, {28'd0, be_s}, {28'd0, v.be});
            if (v.we) chk({tag, "_wdata"}, wd_s, v.mwd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rd       wr       addr       wdata         mem           ack we be       mwd           rdata         err busy
        vecs[0]  = mk(4'b0000, 3'b100, 32'h103, 32'h000000AB, 32'h0,        2, 1, 4'b1000, 32'hABABABAB, 32'h00000000, 0, 3);
        vecs[1]  = mk(4'b1000, 3'b000, 32'h202, 32'h0,        32'h80FF1234, 1, 0, 4'b0000, 32'h0,        32'hFFFFFFFF, 0, 2);
        vecs[2]  = mk(4'b1100, 3'b000, 32'h202, 32'h0,        32'h80FF1234, 1, 0, 4'b0000, 32'h0,        32'h000000FF, 0, 2);
        vecs[3]  = mk(4'b1001, 3'b000, 32'h202, 32'h0,        32'h80FF1234, 1, 0, 4'b0000, 32'h0,        32'hFFFF80FF, 0, 2);
        vecs[4]  = mk(4'b1101, 3'b000, 32'h200, 32'h0,        32'h80FF1234, 1, 0, 4'b0000, 32'h0,        32'h00001234, 0, 2);
        vecs[5]  = mk(4'b0000, 3'b101, 32'h302, 32'h1234CDEF, 32'h0,        1, 1, 4'b1100, 32'hCDEFCDEF, 32'h00001234, 0, 2);
        vecs[6]  = mk(4'b1010, 3'b000, 32'h301, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h00000000, 1, 1);
        vecs[7]  = mk(4'b1010, 3'b000, 32'h204, 32'h0,        32'hDEADBEEF, 3, 0, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 4);
        vecs[8]  = mk(4'b0000, 3'b101, 32'h101, 32'h1111,     32'h0,        0, 1, 4'b0000, 32'h0,        32'h00000000, 1, 1);
        vecs[9]  = mk(4'b1011, 3'b000, 32'h208, 32'h0,        32'h12345678, 1, 0, 4'b0000, 32'h0,        32'h12345678, 0, 2);
        vecs[10] = mk(4'b0000, 3'b111, 32'h100, 32'h55,       32'h0,        0, 1, 4'b0000, 32'h0,        32'h00000000, 1, 1);
        vecs[11] = mk(4'b1110, 3'b000, 32'h20C, 32'h0,        32'h0BADF00D, 2, 0, 4'b0000, 32'h0,        32'h0BADF00D, 0, 3);
        vecs[12] = mk(4'b1010, 3'b000, 32'h400, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h00000000, 1, 5);
        vecs[13] = mk(4'b1010, 3'b110, 32'h500, 32'h11223344, 32'h0,        1, 1, 4'b1111, 32'h11223344, 32'h00000000, 0, 2);
        vecs[14] = mk(4'b1010, 3'b000, 32'h504, 32'h0,        32'hCAFEF00D, 1, 0, 4'b0000, 32'h0,        32'hCAFEF00D, 0, 2);
        vecs[15] = mk(4'b0000, 3'b100, 32'h100, 32'h0000005A, 32'h0,        1, 1, 4'b0001, 32'h5A5A5A5A, 32'hCAFEF00D, 0, 2);
        vecs[16] = mk(4'b1000, 3'b000, 32'h201, 32'h0,        32'h00007F00, 1, 0, 4'b0000, 32'h0,        32'h0000007F, 0, 2);
        vecs[17] = mk(4'b1010, 3'b000, 32'h600, 32'h0,        32'h55AA55AA, 4, 0, 4'b0000, 32'h0,        32'h55AA55AA, 0, 5);

        RESET = 1'b1;
        DATA_MEM_READ = 4'b0; DATA_MEM_WRITE = 3'b0;
        DATA_MEM_ADDR = 32'h0; DATA_MEM_WRITE_DATA = 32'h0;
        MEM_READ_DATA = 32'h0; MEM_ACK = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset_req",   {31'd0, MEM_REQ}, 32'd0);
        chk("reset_we",    {31'd0, MEM_WE}, 32'd0);
        chk("reset_be",    {28'd0, MEM_BYTE_EN}, 32'd0);
        chk("reset_err",   {31'd0, DATA_MEM_ERROR}, 32'd0);
        chk("reset_rdata", DATA_MEM_READ_DATA, 32'd0);
        chk("reset_busy",  {31'd0, DATA_MEM_BUSYWAIT}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 18; i++) run_txn(vecs[i], i);

        // Reset in the second ACCESS cycle abandons the transaction.
        DATA_MEM_READ = 4'b1010; DATA_MEM_WRITE = 3'b000; DATA_MEM_ADDR = 32'h700;
        @(negedge CLK);
        #1 chk("rst_access_req", {31'd0, MEM_REQ}, 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        DATA_MEM_READ = 4'b0000;
        @(negedge CLK);
        #1;
        chk("rst_mid_req",   {31'd0, MEM_REQ}, 32'd0);
        chk("rst_mid_we",    {31'd0, MEM_WE}, 32'd0);
        chk("rst_mid_be",    {28'd0, MEM_BYTE_EN}, 32'd0);
        chk("rst_mid_err",   {31'd0, DATA_MEM_ERROR}, 32'd0);
        chk("rst_mid_rdata", DATA_MEM_READ_DATA, 32'd0);
        chk("rst_mid_busy",  {31'd0, DATA_MEM_BUSYWAIT}, 32'd0);
        RESET = 1'b0;
        MEM_ACK = 1'b1;
        MEM_READ_DATA = 32'hFFFFFFFF;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        #1;
        chk("late_ack_rdata", DATA_MEM_READ_DATA, 32'd0);
        chk("late_ack_req",   {31'd0, MEM_REQ}, 32'd0);
        chk("late_ack_err",   {31'd0, DATA_MEM_ERROR}, 32'd0);
        @(negedge CLK);
        run_txn(mk(4'b1010, 3'b000, 32'h800, 32'h0, 32'h13579BDF, 1, 0, 4'b0000, 32'h0,
                   32'h13579BDF, 0, 2), 18);
        DATA_MEM_READ = 4'b0000; DATA_MEM_WRITE = 3'b000;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
